// File: rtl/sp_ram_dma_pkg.sv
// -----------------------------------------------------------------------------
// sp_ram_dma_pkg
// Shared types and constants for the single-port RAM DMA initiator.
//   mode_e  : command encoding seen on mode_i (FILL / COPY / CHECK / reserved)
//   state_e : sequencer states of the top-level FSM
//   BE_FULL : byte-enable for a full 32-bit write
//   BE_NONE : byte-enable driven on reads and idle cycles
// -----------------------------------------------------------------------------
package sp_ram_dma_pkg;

    typedef enum logic [1:0] {
        MODE_FILL  = 2'd0,
        MODE_COPY  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_CP_RD,
        ST_CP_WR,
        ST_CHK,
        ST_DRAIN,
        ST_FIN
    } state_e;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

endpackage

// File: rtl/sp_ram_dma_initiator_if.sv
// -----------------------------------------------------------------------------
// sp_ram_dma_initiator_if
// Single-port 32-bit RAM bus with one cycle of read latency.
//   en    : access enable           (master -> slave)
//   addr  : byte address, [1:0]=0   (master -> slave)
//   wdata : write data              (master -> slave)
//   we    : 1 write, 0 read         (master -> slave)
//   be    : byte enables            (master -> slave)
//   rdata : read data, valid the cycle after a read (slave -> master)
// -----------------------------------------------------------------------------
interface sp_ram_dma_initiator_if #(
    parameter int ADDR_WIDTH = 12
) ();

    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           rdata;

    modport master (output en, addr, wdata, we, be, input rdata);
    modport slave  (input en, addr, wdata, we, be, output rdata);

endinterface

// File: rtl/sp_ram_dma_chk.sv
// -----------------------------------------------------------------------------
// sp_ram_dma_chk
// Compare pipeline for CHECK commands. A read request is presented together
// with the value it should return; one cycle later the returned RAM data is
// compared against it.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   clear_i               : wipe statistics and any pending compare
//   valid_i               : a CHECK read is on the bus this cycle
//   expected_i, addr_i    : expected word and byte address of that read
//   actual_i              : RAM read data (belongs to last cycle's read)
//   mismatch_o            : compare of this cycle failed (combinational)
//   mismatch_cnt_o        : saturating mismatch count
//   first_mismatch_addr_o : byte address of the first mismatch
// -----------------------------------------------------------------------------
module sp_ram_dma_chk
    import sp_ram_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic [31:0]           expected_i,
    input  logic [31:0]           actual_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  mismatch_o,
    output logic [LEN_WIDTH-1:0]  mismatch_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_mismatch_addr_o
);

    logic                  r_valid;
    logic [31:0]           r_expected;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [ADDR_WIDTH-1:0] r_first;
    logic                  w_mismatch;

    assign w_mismatch = r_valid && (actual_i != r_expected);

    // NOTE: payload registers need no reset; r_valid alone decides whether they are used.
    always_ff @(posedge clk_i) begin
        r_expected <= expected_i;
        r_addr     <= addr_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_first <= '0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_first <= '0;
        end else begin
            r_valid <= valid_i;
            if (w_mismatch) begin
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + LEN_WIDTH'(1);
                end
                // The counter never wraps back to zero, so zero means "no mismatch yet".
                if (r_cnt == '0) begin
                    r_first <= r_addr;
                end
            end
        end
    end

    assign mismatch_o            = w_mismatch;
    assign mismatch_cnt_o        = r_cnt;
    assign first_mismatch_addr_o = r_first;

endmodule

// File: rtl/sp_ram_dma_initiator.sv
// -----------------------------------------------------------------------------
// sp_ram_dma_initiator
// Executes one FILL, COPY or CHECK command at a time over a single-port RAM.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   start_i               : command strobe, honoured only in IDLE
//   mode_i                : 0 FILL, 1 COPY, 2 CHECK, 3 reserved (error)
//   src_addr_i/dst_addr_i : byte base addresses (low two bits ignored)
//   len_i                 : number of 32-bit words
//   pattern_i             : word i uses pattern_i + i
//   busy_o, done_o, err_o : status; done_o pulses once per command
//   mismatch_cnt_o        : CHECK mismatch count (saturating)
//   first_mismatch_addr_o : byte address of the first CHECK mismatch
//   ram                   : RAM master port
// All outputs come from registers except the COPY write data, which forwards
// ram.rdata in the write cycle: the word read in the previous cycle only
// arrives in the cycle it must be written.
// -----------------------------------------------------------------------------
module sp_ram_dma_initiator
    import sp_ram_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [31:0]           pattern_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [LEN_WIDTH-1:0]  mismatch_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_mismatch_addr_o,
    sp_ram_dma_initiator_if.master ram
);

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_src;       // next source address to read
    logic [ADDR_WIDTH-1:0] r_dst;       // next destination address to write
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;       // words issued so far
    logic [31:0]           r_data;      // pattern + (next word index)
    logic [31:0]           r_exp;       // expected value of the read on the bus
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic [3:0]            r_be;

    mode_e                 w_mode;
    logic [ADDR_WIDTH-1:0] w_src;
    logic [ADDR_WIDTH-1:0] w_dst;
    logic                  w_clear;
    logic                  w_chk_valid;
    logic                  w_mismatch;

    assign w_mode      = mode_e'(mode_i);
    assign w_src       = {src_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_dst       = {dst_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_clear     = (r_state == ST_IDLE) && start_i;
    assign w_chk_valid = (r_state == ST_CHK) && r_en;

    sp_ram_dma_chk #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_chk (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .clear_i               (w_clear),
        .valid_i               (w_chk_valid),
        .expected_i            (r_exp),
        .actual_i              (ram.rdata),
        .addr_i                (r_addr),
        .mismatch_o            (w_mismatch),
        .mismatch_cnt_o        (mismatch_cnt_o),
        .first_mismatch_addr_o (first_mismatch_addr_o)
    );

    // NOTE: non-blocking assignments so every branch sees the pre-edge register values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_exp   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_en    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_be    <= BE_NONE;
        end else begin
            if (w_mismatch) begin
                r_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_len <= len_i;
                        r_cnt <= LEN_WIDTH'(1);
                        r_err <= (w_mode == MODE_RSVD);
                        if (len_i == '0 || w_mode == MODE_RSVD) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            // The first access goes out in the cycle right after acceptance.
                            r_busy <= 1'b1;
                            r_en   <= 1'b1;
                            case (w_mode)
                                MODE_FILL: begin
                                    r_we    <= 1'b1;
                                    r_be    <= BE_FULL;
                                    r_addr  <= w_dst;
                                    r_wdata <= pattern_i;
                                    r_dst   <= w_dst + WORD_STEP;
                                    r_data  <= pattern_i + 32'd1;
                                    r_state <= ST_FILL;
                                end
                                MODE_COPY: begin
                                    r_we    <= 1'b0;
                                    r_be    <= BE_NONE;
                                    r_addr  <= w_src;
                                    r_src   <= w_src + WORD_STEP;
                                    r_dst   <= w_dst;
                                    r_state <= ST_CP_RD;
                                end
                                MODE_CHECK: begin
                                    r_we    <= 1'b0;
                                    r_be    <= BE_NONE;
                                    r_addr  <= w_src;
                                    r_exp   <= pattern_i;
                                    r_src   <= w_src + WORD_STEP;
                                    r_data  <= pattern_i + 32'd1;
                                    r_state <= ST_CHK;
                                end
                                default: r_state <= ST_IDLE;
                            endcase
                        end
                    end
                end

                ST_FILL: begin
                    if (r_cnt == r_len) begin
                        r_en    <= 1'b0;
                        r_we    <= 1'b0;
                        r_be    <= BE_NONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_addr  <= r_dst;
                        r_wdata <= r_data;
                        r_dst   <= r_dst + WORD_STEP;
                        r_data  <= r_data + 32'd1;
                        r_cnt   <= r_cnt + LEN_WIDTH'(1);
                    end
                end

                ST_CP_RD: begin
                    r_we    <= 1'b1;
                    r_be    <= BE_FULL;
                    r_addr  <= r_dst;
                    r_dst   <= r_dst + WORD_STEP;
                    r_state <= ST_CP_WR;
                end

                ST_CP_WR: begin
                    // Keep the forwarded word so wdata holds once the bus goes quiet.
                    r_wdata <= ram.rdata;
                    if (r_cnt == r_len) begin
                        r_en    <= 1'b0;
                        r_we    <= 1'b0;
                        r_be    <= BE_NONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_we    <= 1'b0;
                        r_be    <= BE_NONE;
                        r_addr  <= r_src;
                        r_src   <= r_src + WORD_STEP;
                        r_cnt   <= r_cnt + LEN_WIDTH'(1);
                        r_state <= ST_CP_RD;
                    end
                end

                ST_CHK: begin
                    if (r_cnt == r_len) begin
                        r_en    <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_addr <= r_src;
                        r_exp  <= r_data;
                        r_src  <= r_src + WORD_STEP;
                        r_data <= r_data + 32'd1;
                        r_cnt  <= r_cnt + LEN_WIDTH'(1);
                    end
                end

                // The last read's data is compared during this cycle.
                ST_DRAIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_FIN;
                end

                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign ram.en    = r_en;
    assign ram.addr  = r_addr;
    assign ram.wdata = (r_state == ST_CP_WR) ? ram.rdata : r_wdata;
    assign ram.we    = r_we;
    assign ram.be    = r_be;

endmodule
